// File: rtl/adf4159_spi_seq.sv
`timescale 1ns/1ps
// adf4159_spi_seq: AXI4-Lite queued SPI sequencer driving one or more ADF4159 PLLs.
// Define ADF_SPI_RXCAP_EN to add MUXOUT readback capture (spi_muxout port, RXDATA at 0x10).
module adf4159_spi_seq #(
  parameter int unsigned NUM_CH     = 1,
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned LE_GAP     = 4
) (
  input  logic              s00_axi_aclk,
  input  logic              s00_axi_aresetn,
  input  logic [4:0]        s00_axi_awaddr,
  input  logic [2:0]        s00_axi_awprot,
  input  logic              s00_axi_awvalid,
  output logic              s00_axi_awready,
  input  logic [31:0]       s00_axi_wdata,
  input  logic [3:0]        s00_axi_wstrb,
  input  logic              s00_axi_wvalid,
  output logic              s00_axi_wready,
  output logic [1:0]        s00_axi_bresp,
  output logic              s00_axi_bvalid,
  input  logic              s00_axi_bready,
  input  logic [4:0]        s00_axi_araddr,
  input  logic [2:0]        s00_axi_arprot,
  input  logic              s00_axi_arvalid,
  output logic              s00_axi_arready,
  output logic [31:0]       s00_axi_rdata,
  output logic [1:0]        s00_axi_rresp,
  output logic              s00_axi_rvalid,
  input  logic              s00_axi_rready,
  output logic              spi_sclk,
  output logic              spi_sdata,
  output logic [NUM_CH-1:0] spi_le,
`ifdef ADF_SPI_RXCAP_EN
  input  logic              spi_muxout,
`endif
  output logic              irq
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ENT_W = WORD_W + 3;
  localparam int unsigned CNT_W = ($clog2(LE_GAP + 1) > 8) ? $clog2(LE_GAP + 1) : 8;
  localparam int unsigned BIT_W = $clog2(WORD_W);

  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_SHIFT, S_LATCH, S_GAP} state_t;

  state_t            state;
  logic              en, ie, ovf, rxv;
  logic [2:0]        ch_sel;
  logic [7:0]        clkdiv;
  logic [ENT_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level;
  logic [WORD_W-1:0] shreg;
  logic [7:0]        hdiv;
  logic [CNT_W-1:0]  cnt;
  logic [BIT_W-1:0]  bitn;
  logic [NUM_CH-1:0] le_sel;
  logic [31:0]       rd_mux, rx_word;
  logic [ENT_W-1:0]  head;
  logic [2:0]        head_ch;
  logic [WORD_W-1:0] head_word;
  logic [2:0]        wr_sel, rd_sel;
  logic              wr_fire, rd_fire, fifo_full, fifo_empty, ch_ok;
  logic              push_req, push, pop, latch_done, sclk_rise, busy;
  logic              unused;

  assign wr_fire    = s00_axi_awready & s00_axi_awvalid & s00_axi_wvalid;
  assign rd_fire    = s00_axi_arready & s00_axi_arvalid;
  assign wr_sel     = s00_axi_awaddr[4:2];
  assign rd_sel     = s00_axi_araddr[4:2];
  assign fifo_full  = (level == LVL_W'(FIFO_DEPTH));
  assign fifo_empty = (level == '0);
  assign ch_ok      = (32'(ch_sel) < NUM_CH);
  assign push_req   = wr_fire && (wr_sel == 3'd1);
  // Fullness is judged before any same-cycle pop, so a full FIFO always rejects.
  assign push       = push_req && !fifo_full && ch_ok;
  assign pop        = (state == S_IDLE) && en && !fifo_empty;
  assign latch_done = (state == S_LATCH) && (cnt == '0);
  assign sclk_rise  = (cnt == '0) && ((state == S_LEAD) || (state == S_SHIFT && !spi_sclk));
  assign busy       = (state != S_IDLE) || !fifo_empty;
  assign head       = mem[rd_ptr];
  assign head_ch    = head[ENT_W-1 -: 3];
  assign head_word  = head[WORD_W-1:0];
  assign unused     = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_wstrb, s00_axi_awaddr[1:0],
                        s00_axi_araddr[1:0], s00_axi_wdata, shreg[WORD_W-1]};

  always_comb begin
    le_sel = '1;
    for (int unsigned i = 0; i < NUM_CH; i++) le_sel[i] = (32'(head_ch) != i);
  end

  always_comb begin
    rd_mux = '0;
    case (rd_sel)
      3'd0: rd_mux = {25'b0, ch_sel, 2'b00, ie, en};
      3'd2: rd_mux = {17'b0, 7'(level), 3'b000, rxv, ovf, fifo_empty, fifo_full, busy};
      3'd3: rd_mux = {24'b0, clkdiv};
      3'd4: rd_mux = rx_word;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (push) mem[wr_ptr] <= {ch_sel, s00_axi_wdata[WORD_W-1:0]};
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      s00_axi_awready <= 1'b0;
      s00_axi_wready  <= 1'b0;
      s00_axi_bvalid  <= 1'b0;
      s00_axi_bresp   <= '0;
      s00_axi_arready <= 1'b0;
      s00_axi_rvalid  <= 1'b0;
      s00_axi_rdata   <= '0;
      s00_axi_rresp   <= '0;
      en              <= 1'b0;
      ie              <= 1'b0;
      ch_sel          <= '0;
      clkdiv          <= '0;
      ovf             <= 1'b0;
      wr_ptr          <= '0;
      level           <= '0;
      irq             <= 1'b0;
    end else begin
      s00_axi_awready <= s00_axi_awvalid & s00_axi_wvalid & !s00_axi_bvalid & !s00_axi_awready;
      s00_axi_wready  <= s00_axi_awvalid & s00_axi_wvalid & !s00_axi_bvalid & !s00_axi_awready;
      if (wr_fire) begin
        s00_axi_bvalid <= 1'b1;
        s00_axi_bresp  <= (push_req && !push) ? 2'b10 : 2'b00;
        case (wr_sel)
          3'd0: begin
            en     <= s00_axi_wdata[0];
            ie     <= s00_axi_wdata[1];
            ch_sel <= s00_axi_wdata[6:4];
          end
          3'd2: if (s00_axi_wdata[3]) ovf <= 1'b0;
          3'd3: clkdiv <= s00_axi_wdata[7:0];
          default: ;
        endcase
      end else if (s00_axi_bvalid && s00_axi_bready) begin
        s00_axi_bvalid <= 1'b0;
      end
      if (push_req && fifo_full) ovf <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
      s00_axi_arready <= s00_axi_arvalid & !s00_axi_rvalid & !s00_axi_arready;
      if (rd_fire) begin
        s00_axi_rvalid <= 1'b1;
        s00_axi_rdata  <= rd_mux;
      end else if (s00_axi_rvalid && s00_axi_rready) begin
        s00_axi_rvalid <= 1'b0;
      end
      irq <= ie && fifo_empty && (state == S_IDLE);
    end
  end

  // Half-period counter: each phase lasts hdiv+1 clocks; hdiv/channel latched at pop.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state     <= S_IDLE;
      spi_sclk  <= 1'b0;
      spi_sdata <= 1'b0;
      spi_le    <= '1;
      shreg     <= '0;
      hdiv      <= '0;
      cnt       <= '0;
      bitn      <= '0;
      rd_ptr    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            rd_ptr    <= rd_ptr + 1'b1;
            shreg     <= head_word;
            spi_sdata <= head_word[WORD_W-1];
            spi_le    <= le_sel;
            hdiv      <= clkdiv;
            cnt       <= CNT_W'(clkdiv);
            bitn      <= '0;
            state     <= S_LEAD;
          end
        end
        S_LEAD: begin
          if (cnt == '0) begin
            spi_sclk <= 1'b1;
            cnt      <= CNT_W'(hdiv);
            state    <= S_SHIFT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_SHIFT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!spi_sclk) begin
            spi_sclk <= 1'b1;
            cnt      <= CNT_W'(hdiv);
          end else begin
            spi_sclk <= 1'b0;
            cnt      <= CNT_W'(hdiv);
            if (bitn == BIT_W'(WORD_W - 1)) begin
              spi_sdata <= 1'b0;
              state     <= S_LATCH;
            end else begin
              bitn      <= bitn + 1'b1;
              shreg     <= {shreg[WORD_W-2:0], 1'b0};
              spi_sdata <= shreg[WORD_W-2];
            end
          end
        end
        S_LATCH: begin
          if (cnt == '0) begin
            spi_le <= '1;
            cnt    <= CNT_W'(LE_GAP - 1);
            state  <= S_GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == '0) state <= S_IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ADF_SPI_RXCAP_EN
  logic [WORD_W-1:0] rxsh, rxdata;

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      rxsh   <= '0;
      rxdata <= '0;
      rxv    <= 1'b0;
    end else begin
      if (sclk_rise) rxsh <= {rxsh[WORD_W-2:0], spi_muxout};
      if (latch_done) begin
        rxdata <= rxsh;
        rxv    <= 1'b1;
      end else if (rd_fire && rd_sel == 3'd4) begin
        rxv <= 1'b0;
      end
    end
  end

  assign rx_word = 32'(rxdata);
`else
  logic unused_rx;
  assign unused_rx = ^{sclk_rise, latch_done};
  assign rxv       = 1'b0;
  assign rx_word   = '0;
`endif

endmodule

// File: tb/tb_adf4159_spi_seq.sv
`timescale 1ns/1ps
// Directed bench for adf4159_spi_seq: two channels, 4-deep FIFO, LE_GAP of 8.
module tb_adf4159_spi_seq;
  localparam int NCH = 2;
  localparam int GAP = 8;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [4:0]  awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        spi_sclk, spi_sdata, irq;
  logic [NCH-1:0] spi_le;
  logic        spi_muxout = 1'b0;
  logic [31:0] rx_pat = 32'hA5A5_5A5A;
  int          rx_idx = 31;
  int          errors = 0, checks = 0, cyc = 0;

  adf4159_spi_seq #(.NUM_CH(NCH), .WORD_W(32), .FIFO_DEPTH(4), .LE_GAP(GAP)) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
    .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
    .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
    .s00_axi_rready(rready), .spi_sclk(spi_sclk), .spi_sdata(spi_sdata), .spi_le(spi_le),
`ifdef ADF_SPI_RXCAP_EN
    .spi_muxout(spi_muxout),
`endif
    .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=no finish expected=finish within 1ms");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tmo_fail(input string tag);
    checks++;
    errors++;
    $display("FAIL %s: observed=timeout expected=handshake", tag);
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, output logic [1:0] resp);
    int n;
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (!awready && n < 16) begin @(posedge clk); #1; n++; end
    if (!awready) tmo_fail("awready");
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    n = 0;
    while (!bvalid && n < 16) begin @(posedge clk); #1; n++; end
    if (!bvalid) tmo_fail("bvalid");
    resp = bresp;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
    int n;
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 16) begin @(posedge clk); #1; n++; end
    if (!arready) tmo_fail("arready");
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    n = 0;
    while (!rvalid && n < 16) begin @(posedge clk); #1; n++; end
    if (!rvalid) tmo_fail("rvalid");
    d = rdata;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  // Follows one frame: decodes SDATA on SCLK rises, drives MUXOUT on falls.
  task automatic mon_frame(input int period, output logic [31:0] word, output int rises,
                           output int pbad, output int fall_to_le, output int ch,
                           output int obad, output int t_fall, output int t_rise);
    int n, last_rise, last_fall;
    logic prev;
    word = '0; rises = 0; pbad = 0; obad = 0; ch = 0; last_rise = -1; last_fall = 0;
    n = 0;
    while (spi_le == '1 && n < 400) begin @(posedge clk); #1; n++; end
    if (spi_le == '1) tmo_fail("le_fall");
    for (int i = NCH - 1; i >= 0; i--) if (!spi_le[i]) ch = i;
    t_fall = cyc;
    prev = spi_sclk;
    n = 0;
    while (spi_le[ch] == 1'b0 && n < 1000) begin
      @(posedge clk); #1; n++;
      if (!prev && spi_sclk) begin
        rises++;
        word = {word[30:0], spi_sdata};
        if (last_rise >= 0 && cyc - last_rise != period) pbad++;
        last_rise = cyc;
      end
      if (prev && !spi_sclk) begin
        last_fall = cyc;
        if (rx_idx > 0) begin rx_idx--; spi_muxout = rx_pat[rx_idx]; end
      end
      for (int i = 0; i < NCH; i++) if (i != ch && !spi_le[i]) obad++;
      prev = spi_sclk;
    end
    if (spi_le[ch] == 1'b0) tmo_fail("le_rise");
    t_rise = cyc;
    fall_to_le = t_rise - last_fall;
  endtask

  initial begin
    logic [31:0] d, w;
    logic [1:0]  r;
    int rises, pbad, f2l, ch, obad, tf, tr, tr1, tf2, tr2, n;

    repeat (3) @(posedge clk); #1;
    chk("rst_le", 32'(spi_le), 32'h3);
    chk("rst_sclk", 32'(spi_sclk), 32'h0);
    chk("rst_sdata", 32'(spi_sdata), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_axi", 32'({awready, wready, bvalid, arready, rvalid, bresp, rresp}), 32'h0);
    rst_n = 1'b1;
    axi_read(5'h00, d); chk("ctrl_rst", d, 32'h0);
    axi_read(5'h08, d); chk("status_rst", d, 32'h4);
    axi_read(5'h0C, d); chk("clkdiv_rst", d, 32'h0);

    // Single frame, H=2
    axi_write(5'h0C, 32'h1, r);
    axi_write(5'h00, 32'h1, r);
    axi_write(5'h04, 32'h0000_8007, r); chk("tx_bresp", 32'(r), 32'h0);
    mon_frame(4, w, rises, pbad, f2l, ch, obad, tf, tr);
    chk("f1_word", w, 32'h0000_8007);
    chk("f1_rises", 32'(rises), 32'd32);
    chk("f1_period", 32'(pbad), 32'd0);
    chk("f1_fall_to_le", 32'(f2l), 32'd2);
    chk("f1_ch", 32'(ch), 32'd0);
    chk("f1_other_le", 32'(obad), 32'd0);
    chk("f1_sdata_idle", 32'(spi_sdata), 32'h0);

    // Two channels queued with EN=0, then released
    axi_write(5'h00, 32'h00, r);
    axi_write(5'h04, 32'h11, r);
    axi_write(5'h00, 32'h10, r);
    axi_write(5'h04, 32'h22, r);
    axi_read(5'h08, d); chk("lvl2", d, 32'h201);
    axi_write(5'h00, 32'h13, r);
    mon_frame(4, w, rises, pbad, f2l, ch, obad, tf, tr);
    tr1 = tr;
    chk("fa_word", w, 32'h11);
    chk("fa_ch", 32'(ch), 32'd0);
    axi_read(5'h08, d); chk("lvl1", d, 32'h101);
    mon_frame(4, w, rises, pbad, f2l, ch, obad, tf2, tr2);
    chk("fb_word", w, 32'h22);
    chk("fb_ch", 32'(ch), 32'd1);
    chk("fb_other_le", 32'(obad), 32'd0);
    chk("fb_gap_ok", 32'(tf2 - tr1 >= GAP), 32'd1);
    chk("irq_in_gap", 32'(irq), 32'h0);
    n = 0;
    while (!irq && n < 40) begin @(posedge clk); #1; n++; end
    chk("irq_rise", 32'(irq), 32'h1);
    chk("irq_after_gap", 32'(cyc - tr2 >= GAP), 32'd1);
    axi_read(5'h08, d); chk("lvl0", d, 32'h4);

    // Rejections: bad channel, then overflow
    axi_write(5'h00, 32'h20, r);
    axi_write(5'h04, 32'h55, r); chk("badch_bresp", 32'(r), 32'h2);
    axi_read(5'h08, d); chk("badch_status", d, 32'h4);
    axi_write(5'h00, 32'h00, r);
    for (int i = 0; i < 4; i++) axi_write(5'h04, 32'(i), r);
    chk("fill_bresp", 32'(r), 32'h0);
    axi_read(5'h08, d); chk("full_status", d, 32'h403);
    axi_write(5'h04, 32'h99, r); chk("ovf_bresp", 32'(r), 32'h2);
    axi_read(5'h08, d); chk("ovf_status", d, 32'h40B);
    axi_write(5'h08, 32'h8, r);
    axi_read(5'h08, d); chk("ovf_clear", d, 32'h403);

    // Asynchronous reset in the middle of a frame
    axi_write(5'h00, 32'h1, r);
    n = 0; rises = 0;
    begin
      logic prev;
      prev = spi_sclk;
      while (rises < 10 && n < 200) begin
        @(posedge clk); #1; n++;
        if (!prev && spi_sclk) rises++;
        prev = spi_sclk;
      end
    end
    chk("pre_rst_rises", 32'(rises), 32'd10);
    chk("pre_rst_sclk", 32'(spi_sclk), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_sclk", 32'(spi_sclk), 32'h0);
    chk("arst_le", 32'(spi_le), 32'h3);
    chk("arst_sdata", 32'(spi_sdata), 32'h0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    axi_read(5'h08, d); chk("arst_status", d, 32'h4);
    axi_read(5'h00, d); chk("arst_ctrl", d, 32'h0);

`ifdef ADF_SPI_RXCAP_EN
    axi_write(5'h0C, 32'h1, r);
    rx_idx = 31;
    spi_muxout = rx_pat[31];
    axi_write(5'h00, 32'h1, r);
    axi_write(5'h04, 32'h1234_5678, r);
    mon_frame(4, w, rises, pbad, f2l, ch, obad, tf, tr);
    chk("rx_frame_word", w, 32'h1234_5678);
    repeat (12) @(posedge clk); #1;
    axi_read(5'h08, d); chk("rxv_set", d, 32'h14);
    axi_read(5'h10, d); chk("rxdata", d, 32'hA5A5_5A5A);
    axi_read(5'h08, d); chk("rxv_clear", d, 32'h4);
`else
    axi_read(5'h10, d); chk("rxdata_absent", d, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
